firebird7_in_gate1_tessent_tdr_data_ctl_w3: RTL
===============================================

# firebird7_in_gate1_tessent_tdr_data_ctl_w3

IJTAG test data register (TDR) that controls a functional/IJTAG data mux. It captures the mux output, shifts it out on the IJTAG scan path, and drives the mux select and IJTAG data from an update stage. A shift-length check can block updates that follow a malformed scan. It sits on the IJTAG network between the SIB/scan-mux fabric and the `firebird7_in_gate1` data-mux instances.

## Interface
- `WIDTH`, default 3: width of the controlled data bus.
- `RESET_DATA`, default 0: reset value of `ijtag_data_out`, WIDTH bits.
- `UPDATE_GUARD`, default 1: 1 blocks an update unless exactly WIDTH+1 shifts occurred since the last capture/update; 0 always updates.

- `ijtag_tck` in 1: the only clock; every register is rising-edge.
- `ijtag_reset` in 1: synchronous, active-high reset.
- `ijtag_sel` in 1: TDR selected; all ce/se/ue are ignored when 0.
- `ijtag_ce` in 1: capture enable.
- `ijtag_se` in 1: shift enable.
- `ijtag_ue` in 1: update enable.
- `ijtag_si` in 1: scan in.
- `ijtag_so` out 1: scan out, equal to `sr[0]`.
- `capture_data_in` in WIDTH: observed mux output.
- `ijtag_select` out 1: mux select; 1 selects the IJTAG data path.
- `ijtag_data_out` out WIDTH: IJTAG data to the mux.
- `scan_len_ok` out 1: 1 when the last accepted update followed exactly WIDTH+1 shifts.
- `update_rejected` out 1: sticky; set when a guarded update is blocked.

## Operation
- State:
  - `sr[WIDTH:0]`: shift register. `sr[WIDTH]` holds the select bit; `sr[WIDTH-1:0]` holds the data.
  - `ur[WIDTH:0]`: update register, which drives `ijtag_select` and `ijtag_data_out`.
  - `cnt`: shift counter, saturating at WIDTH+2.
- Scan length LEN = WIDTH+1.
- At most one operation per cycle, priority capture > shift > update, and only when `ijtag_sel`=1.
- Capture: `sr` <= {`ur[WIDTH]`, `capture_data_in`}; `cnt` <= 0.
- Shift: `sr` <= {`ijtag_si`, `sr[WIDTH:1]`}, so LSB exits first; `cnt` <= min(`cnt`+1, WIDTH+2).
- Update:
  - Accepted if `UPDATE_GUARD`=0 or `cnt`==LEN. Then `ur` <= `sr` and `scan_len_ok` <= (`cnt`==LEN).
  - Otherwise `ur` holds, `scan_len_ok` <= 0, and `update_rejected` <= 1.
  - `cnt` <= 0 in both cases.
- Idle (no enable, or `ijtag_sel`=0): all state holds.
- `update_rejected` is cleared only by reset.

## Timing
- Reset values, taking effect on the first rising edge with `ijtag_reset`=1:
  - `sr`=0, `cnt`=0.
  - `ur`={1'b0, `RESET_DATA`}, so `ijtag_select`=0 (functional path) and `ijtag_data_out`=`RESET_DATA`.
  - `scan_len_ok`=0, `update_rejected`=0, `ijtag_so`=0.
- Reset overrides every enable in the same cycle. Reset mid-scan discards the partial scan.
- Outputs are registered and change on the edge that samples the enable:
  - `ijtag_select`/`ijtag_data_out` show the new value in the cycle after `ijtag_ue` is sampled.
  - `ijtag_so` reflects new `sr[0]` immediately after each capture/shift edge.
- Capture samples `capture_data_in` at the edge; the value must be stable for setup around that edge.
- `ijtag_ce` and `ijtag_ue` asserted together: capture only; the update is lost and `cnt` is cleared.
- `ijtag_se` and `ijtag_ue` asserted together: shift only.
- More than LEN shifts: `cnt` saturates at WIDTH+2, and a guarded update is rejected.
- `ijtag_sel` dropping mid-scan freezes `sr`/`cnt`; the scan resumes when it rises again.

## Test plan
- Reset: assert `ijtag_reset` for 1 cycle with `ijtag_ue`=1 and `sr` preloaded -> `ijtag_select`=0, `ijtag_data_out`=`RESET_DATA`, `update_rejected`=0, `ijtag_so`=0.
- Full scan (WIDTH=3): capture, shift `ijtag_si`=1,0,1,1, then update -> `ijtag_select`=1, `ijtag_data_out`=3'b101, `scan_len_ok`=1.
- Capture/observe: with `ur`=4'b1000 and `capture_data_in`=3'b110, capture then 4 shifts -> `ijtag_so` sequence 0,1,1,1.
- Guarded short scan: capture, 3 shifts, update -> outputs unchanged, `update_rejected`=1, `scan_len_ok`=0. A following correct 4-shift scan updates and `update_rejected` stays 1.
- Priority and deselect:
  - `ijtag_ce`+`ijtag_ue` in the same cycle -> capture only, outputs unchanged.
  - Enables with `ijtag_sel`=0 -> no state change.
  - Overlong scan (6 shifts) with `UPDATE_GUARD`=0 -> update applies the last 4 bits shifted, `scan_len_ok`=0.
- Reset mid-scan: reset after 2 shifts, then a correct 4-shift scan and update -> the new value applies, `scan_len_ok`=1.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w3.sv
// rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w3.sv - IJTAG TDR driving select/data of a functional/IJTAG data mux
module firebird7_in_gate1_tessent_tdr_data_ctl_w3 #(
    parameter int               WIDTH        = 3,
    parameter logic [WIDTH-1:0] RESET_DATA   = '0,
    parameter bit               UPDATE_GUARD = 1'b1
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] capture_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             scan_len_ok,
    output logic             update_rejected
);

    localparam int CW = $clog2(WIDTH + 3);
    localparam logic [CW-1:0] CNT_LEN = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 2);

    logic [WIDTH:0]  sr;
    logic [WIDTH:0]  ur;
    logic [CW-1:0]   cnt;
    logic            do_capture;
    logic            do_shift;
    logic            do_update;
    logic            len_ok;
    logic            accept;

    // Capture outranks shift, which outranks update; deselect freezes everything.
    assign do_capture = ijtag_sel & ijtag_ce;
    assign do_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign do_update  = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;
    assign len_ok     = (cnt == CNT_LEN);
    assign accept     = ~UPDATE_GUARD | len_ok;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr              <= '0;
            ur              <= {1'b0, RESET_DATA};
            cnt             <= '0;
            scan_len_ok     <= 1'b0;
            update_rejected <= 1'b0;
        end else if (do_capture) begin
            sr  <= {ur[WIDTH], capture_data_in};
            cnt <= '0;
        end else if (do_shift) begin
            sr <= {ijtag_si, sr[WIDTH:1]};
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end else if (do_update) begin
            cnt <= '0;
            if (accept) begin
                ur          <= sr;
                scan_len_ok <= len_ok;
            end else begin
                scan_len_ok     <= 1'b0;
                update_rejected <= 1'b1;
            end
        end
    end

    assign ijtag_so       = sr[0];
    assign ijtag_select   = ur[WIDTH];
    assign ijtag_data_out = ur[WIDTH-1:0];

endmodule
